// File: rtl/alu_seq_regs_if.sv
// Switch/button input bus and registered result/flag outputs for alu_seq_regs.
// The DUT takes the slave modport; the stimulus side takes master.
interface alu_seq_regs_if #(
  parameter int unsigned NB_DATA = 8
);
  logic [NB_DATA-1:0] i_sw;
  logic               i_btn_a;
  logic               i_btn_b;
  logic               i_btn_op;
  logic [NB_DATA-1:0] o_result;
  logic               o_valid;
  logic               o_zero;
  logic               o_carry;
  logic               o_ovf;

  modport master (
    output i_sw, i_btn_a, i_btn_b, i_btn_op,
    input  o_result, o_valid, o_zero, o_carry, o_ovf
  );

  modport slave (
    input  i_sw, i_btn_a, i_btn_b, i_btn_op,
    output o_result, o_valid, o_zero, o_carry, o_ovf
  );
endinterface

// File: rtl/alu_seq_regs.sv
// Sequentially loaded ALU: buttons latch A, B and opcode from a shared switch bus.
// Define ALU_SEQ_FLAGS_EN to build the zero/carry/overflow status flags.
module alu_seq_regs #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
) (
  input logic          clk,
  input logic          rst,
  alu_seq_regs_if.slave bus
);

  localparam int unsigned NB_EXT = (NB_DATA > NB_OP) ? NB_DATA : NB_OP;

  typedef enum logic [NB_OP-1:0] {
    OP_SLL = 6'b000000,
    OP_SRL = 6'b000010,
    OP_SRA = 6'b000011,
    OP_ADD = 6'b100000,
    OP_SUB = 6'b100010,
    OP_AND = 6'b100100,
    OP_OR  = 6'b100101,
    OP_XOR = 6'b100110,
    OP_NOR = 6'b100111
  } op_e;

  logic [NB_EXT-1:0]  w_sw_ext;
  logic               w_ev_a, w_ev_b, w_ev_op;
  logic               w_big;
  logic [NB_DATA-1:0] w_res;

  logic               r_prev_a, r_prev_b, r_prev_op;
  logic [NB_DATA-1:0] r_a, r_b;
  op_e                r_op;
  logic [2:0]         r_mask;
  logic               r_upd;
  logic [NB_DATA-1:0] r_result;
  logic               r_valid;

  // Zero-extended so the opcode slice stays legal for narrow data widths
  assign w_sw_ext = NB_EXT'(bus.i_sw);

  // A > B > Op; a losing event is dropped because its previous-value still updates
  always_comb begin
    w_ev_a  = bus.i_btn_a  & ~r_prev_a;
    w_ev_b  = bus.i_btn_b  & ~r_prev_b  & ~w_ev_a;
    w_ev_op = bus.i_btn_op & ~r_prev_op & ~w_ev_a & ~w_ev_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_a  <= 1'b1;
      r_prev_b  <= 1'b1;
      r_prev_op <= 1'b1;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= OP_SLL;
      r_mask    <= '0;
      r_upd     <= 1'b0;
    end else begin
      r_prev_a  <= bus.i_btn_a;
      r_prev_b  <= bus.i_btn_b;
      r_prev_op <= bus.i_btn_op;
      if (w_ev_a) begin
        r_a       <= w_sw_ext[NB_DATA-1:0];
        r_mask[2] <= 1'b1;
      end
      if (w_ev_b) begin
        r_b       <= w_sw_ext[NB_DATA-1:0];
        r_mask[1] <= 1'b1;
      end
      if (w_ev_op) begin
        r_op      <= op_e'(w_sw_ext[NB_OP-1:0]);
        r_mask[0] <= 1'b1;
      end
      r_upd <= w_ev_a | w_ev_b | w_ev_op;
    end
  end

  assign w_big = (32'(r_b) >= NB_DATA);

  always_comb begin
    w_res = '0;
    case (r_op)
      OP_ADD: w_res = r_a + r_b;
      OP_SUB: w_res = r_a - r_b;
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_NOR: w_res = ~(r_a | r_b);
      OP_SLL: w_res = w_big ? '0 : (r_a << r_b);
      OP_SRL: w_res = w_big ? '0 : (r_a >> r_b);
      OP_SRA: w_res = w_big ? {NB_DATA{r_a[NB_DATA-1]}} : NB_DATA'($signed(r_a) >>> r_b);
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= r_upd & (&r_mask);
      if (r_upd) r_result <= w_res;
    end
  end

  assign bus.o_result = r_result;
  assign bus.o_valid  = r_valid;

`ifdef ALU_SEQ_FLAGS_EN
  logic w_zero, w_carry, w_ovf;
  logic r_zero, r_carry, r_ovf;

  // Carry/borrow from unsigned compares avoids a widened adder path
  always_comb begin
    w_zero  = (w_res == '0) && (r_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                                             OP_NOR, OP_SLL, OP_SRL, OP_SRA});
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_carry = (w_res < r_a);
        w_ovf   = (r_a[NB_DATA-1] == r_b[NB_DATA-1]) && (w_res[NB_DATA-1] != r_a[NB_DATA-1]);
      end
      OP_SUB: begin
        w_carry = (r_a < r_b);
        w_ovf   = (r_a[NB_DATA-1] != r_b[NB_DATA-1]) && (w_res[NB_DATA-1] != r_a[NB_DATA-1]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_upd) begin
      r_zero  <= w_zero;
      r_carry <= w_carry;
      r_ovf   <= w_ovf;
    end
  end

  assign bus.o_zero  = r_zero;
  assign bus.o_carry = r_carry;
  assign bus.o_ovf   = r_ovf;
`else
  assign bus.o_zero  = 1'b0;
  assign bus.o_carry = 1'b0;
  assign bus.o_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_regs.sv
// Directed bench for alu_seq_regs (NB_DATA=8); flag expectations follow ALU_SEQ_FLAGS_EN.
module tb_alu_seq_regs;

`ifdef ALU_SEQ_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  logic [11:0] e;

  alu_seq_regs_if #(.NB_DATA(8)) bus ();

  alu_seq_regs #(.NB_DATA(8), .NB_OP(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Packed view: {valid, zero, carry, ovf, result}
  function automatic logic [11:0] obs();
    return {bus.o_valid, bus.o_zero, bus.o_carry, bus.o_ovf, bus.o_result};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one sample after the output update (two edges after the press edge)
  task automatic press(input logic [2:0] btns, input logic [7:0] sw);
    bus.i_sw = sw;
    {bus.i_btn_a, bus.i_btn_b, bus.i_btn_op} = btns;
    tick();
    {bus.i_btn_a, bus.i_btn_b, bus.i_btn_op} = 3'b000;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    e = {4'b0000, 8'h00}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL reset_hold: got %h expected %h", obs(), e); end
    rst = 1'b0;
    tick();
    e = {4'b0000, 8'h00}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL reset_release: got %h expected %h", obs(), e); end
  endtask

  task automatic test_add();
    press(3'b100, 8'h7F);
    e = {4'b0000, 8'h7F}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL add_load_a: got %h expected %h", obs(), e); end
    press(3'b010, 8'h01);
    e = {4'b0000, 8'hFE}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL add_load_b: got %h expected %h", obs(), e); end
    press(3'b001, 8'h20);
    e = {1'b1, 1'b0, 1'b0, FL, 8'h80}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL add_op: got %h expected %h", obs(), e); end
    tick();
    e = {1'b0, 1'b0, 1'b0, FL, 8'h80}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL add_pulse_end: got %h expected %h", obs(), e); end
  endtask

  task automatic test_sub();
    press(3'b100, 8'h05);
    e = {4'b1000, 8'h06}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL sub_load_a: got %h expected %h", obs(), e); end
    press(3'b010, 8'h07);
    e = {4'b1000, 8'h0C}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL sub_load_b: got %h expected %h", obs(), e); end
    press(3'b001, 8'h22);
    e = {1'b1, 1'b0, FL, 1'b0, 8'hFE}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL sub_borrow: got %h expected %h", obs(), e); end
    press(3'b010, 8'h05);
    e = {1'b1, FL, 1'b0, 1'b0, 8'h00}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL sub_zero: got %h expected %h", obs(), e); end
  endtask

  task automatic test_shift();
    press(3'b100, 8'h90);
    e = {4'b1000, 8'h8B}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL shf_load_a: got %h expected %h", obs(), e); end
    press(3'b010, 8'h09);
    e = {4'b1000, 8'h87}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL shf_load_b: got %h expected %h", obs(), e); end
    press(3'b001, 8'h03);
    e = {4'b1000, 8'hFF}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL sra_big: got %h expected %h", obs(), e); end
    press(3'b001, 8'h02);
    e = {1'b1, FL, 2'b00, 8'h00}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL srl_big: got %h expected %h", obs(), e); end
    press(3'b010, 8'h02);
    e = {4'b1000, 8'h24}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL srl_2: got %h expected %h", obs(), e); end
    press(3'b001, 8'h00);
    e = {4'b1000, 8'h40}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL sll_2: got %h expected %h", obs(), e); end
  endtask

  task automatic test_logic();
    press(3'b100, 8'hF0);
    e = {4'b1000, 8'hC0}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL log_load_a: got %h expected %h", obs(), e); end
    press(3'b010, 8'h3C);
    e = {1'b1, FL, 2'b00, 8'h00}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL sll_big: got %h expected %h", obs(), e); end
    press(3'b001, 8'h24);
    e = {4'b1000, 8'h30}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL and: got %h expected %h", obs(), e); end
    press(3'b001, 8'h25);
    e = {4'b1000, 8'hFC}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL or: got %h expected %h", obs(), e); end
    press(3'b001, 8'h26);
    e = {4'b1000, 8'hCC}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL xor: got %h expected %h", obs(), e); end
    press(3'b001, 8'h27);
    e = {4'b1000, 8'h03}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL nor: got %h expected %h", obs(), e); end
    press(3'b001, 8'h3F);
    e = {4'b1000, 8'h00}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL bad_op: got %h expected %h", obs(), e); end
    press(3'b001, 8'h20);
    e = {1'b1, 1'b0, FL, 1'b0, 8'h2C}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL add_carry: got %h expected %h", obs(), e); end
  endtask

  task automatic test_priority();
    int pulses;
    bus.i_sw = 8'h33;
    bus.i_btn_a = 1'b1;
    bus.i_btn_b = 1'b1;
    tick();
    bus.i_sw = 8'h11;
    tick();
    e = {4'b1000, 8'h6F}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL pri_a_over_b: got %h expected %h", obs(), e); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.o_valid) pulses++;
    end
    n_chk++;
    if (pulses !== 0) begin n_err++; $display("FAIL held_pulses: got %0d expected 0", pulses); end
    e = {4'b0000, 8'h6F}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL held_result: got %h expected %h", obs(), e); end
    bus.i_btn_a = 1'b0;
    bus.i_btn_b = 1'b0;
    tick();
    press(3'b011, 8'h26);
    e = {4'b1000, 8'h59}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL pri_b_over_op: got %h expected %h", obs(), e); end
  endtask

  task automatic test_reset_mid();
    bus.i_sw = 8'h20;
    bus.i_btn_op = 1'b1;
    tick();
    rst = 1'b1;
    bus.i_btn_op = 1'b0;
    tick();
    e = {4'b0000, 8'h00}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL rst_cancel: got %h expected %h", obs(), e); end
    bus.i_sw = 8'h55;
    bus.i_btn_a = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    e = {4'b0000, 8'h00}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL held_through_rst: got %h expected %h", obs(), e); end
    bus.i_btn_a = 1'b0;
    tick();
    press(3'b100, 8'h55);
    e = {4'b0000, 8'h55}; n_chk++;
    if (obs() !== e) begin n_err++; $display("FAIL a_after_rst: got %h expected %h", obs(), e); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_chk = 0;
    n_err = 0;
    bus.i_sw = '0;
    bus.i_btn_a = 1'b0;
    bus.i_btn_b = 1'b0;
    bus.i_btn_op = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_logic();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
